// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD multiplexed-display scan controller.
package bcd_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  // True when a nibble is a legal BCD digit (0..9).
  function automatic logic bcd_nibble_ok(input logic [BCD_W-1:0] nibble);
    return (nibble <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_decoder.sv
// Combinational 4-to-10 decode of one BCD digit; all-zero when disabled
// or when the code is not a legal digit.
module bcd_digit_decoder
  import bcd_pkg::*;
(
  input  logic             i_en,
  input  logic [BCD_W-1:0] i_code,
  output logic [9:0]       o_onehot
);

  // Decode the active code into a single set bit.
  always_comb begin
    o_onehot = 10'b0;
    if (i_en && bcd_nibble_ok(i_code)) begin
      o_onehot = 10'b00_0000_0001 << i_code;
    end else begin
      o_onehot = 10'b0;
    end
  end

endmodule

// File: rtl/bcd_scan_controller.sv
// Accepts a packed BCD word, rejects it if any nibble is not 0..9, and
// otherwise scans the digits out one at a time, each held for DWELL cycles.
module bcd_scan_controller
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DWELL  = 1000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BCD_W*DIGITS-1:0]   in_bcd,
  input  logic                      loop,
  input  logic                      stop,
  output logic [DIGITS-1:0]         dig_sel,
  output logic [BCD_W-1:0]          dig_code,
  output logic [9:0]                dig_onehot,
  output logic                      scan_busy,
  output logic                      frame_done,
  output logic                      bcd_err
);

  localparam int CNT_W = (DWELL  > 1) ? $clog2(DWELL)  : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  scan_state_e               r_state;
  scan_state_e               w_next_state;
  logic [IDX_W-1:0]          r_idx;
  logic [CNT_W-1:0]          r_cnt;
  logic [BCD_W*DIGITS-1:0]   r_word;
  logic                      r_bcd_err;

  logic                      w_handshake;
  logic                      w_word_ok;
  logic                      w_last;
  logic [BCD_W-1:0]          w_cur_code;
  logic [DIGITS-1:0]         w_dig_sel;
  logic [BCD_W-1:0]          w_dig_code;
  logic                      w_busy;
  logic                      w_frame_done;
  logic [9:0]                w_dig_onehot;

  assign w_handshake = in_valid && (r_state == IDLE);
  assign w_last      = (r_idx == IDX_LAST) && (r_cnt == CNT_LAST);
  assign w_cur_code  = r_word[r_idx*BCD_W +: BCD_W];

  // Validate every nibble of the offered word.
  always_comb begin
    w_word_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_nibble_ok(in_bcd[i*BCD_W +: BCD_W])) begin
        w_word_ok = 1'b0;
      end else begin
        w_word_ok = w_word_ok;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state: stop beats frame completion; loop decides rescan vs idle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_handshake && w_word_ok) begin
          w_next_state = SCAN;
        end else begin
          w_next_state = IDLE;
        end
      end
      SCAN: begin
        if (stop) begin
          w_next_state = IDLE;
        end else if (w_last && !loop) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = SCAN;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs: display drive only while scanning; frame_done masked by stop.
  always_comb begin
    w_dig_sel    = {DIGITS{1'b0}};
    w_dig_code   = 4'd0;
    w_busy       = 1'b0;
    w_frame_done = 1'b0;
    if (r_state == SCAN) begin
      w_dig_sel    = DIGITS'(1'b1) << r_idx;
      w_dig_code   = w_cur_code;
      w_busy       = 1'b1;
      w_frame_done = w_last && !stop;
    end else begin
      w_dig_sel    = {DIGITS{1'b0}};
      w_dig_code   = 4'd0;
      w_busy       = 1'b0;
      w_frame_done = 1'b0;
    end
  end

  // Dwell and digit counters advance only while staying in SCAN; a looped
  // frame wraps naturally to digit 0, and any entry into SCAN starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if ((r_state == SCAN) && (w_next_state == SCAN)) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_idx <= r_idx;
      end
    end else begin
      r_cnt <= '0;
      r_idx <= '0;
    end
  end

  // Latch accepted words; pulse bcd_err for one cycle on a rejected word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word    <= '0;
      r_bcd_err <= 1'b0;
    end else begin
      r_bcd_err <= w_handshake && !w_word_ok;
      if (w_handshake && w_word_ok) begin
        r_word <= in_bcd;
      end else begin
        r_word <= r_word;
      end
    end
  end

  bcd_digit_decoder u_decoder (
    .i_en     (w_busy),
    .i_code   (w_dig_code),
    .o_onehot (w_dig_onehot)
  );

  assign in_ready   = (r_state == IDLE);
  assign dig_sel    = w_dig_sel;
  assign dig_code   = w_dig_code;
  assign dig_onehot = w_dig_onehot;
  assign scan_busy  = w_busy;
  assign frame_done = w_frame_done;
  assign bcd_err    = r_bcd_err;

endmodule

// File: tb/tb_bcd_scan_controller.sv
// Directed scoreboard bench for bcd_scan_controller with DIGITS=4, DWELL=2.
module tb_bcd_scan_controller;

  localparam int DIGITS = 4;
  localparam int DWELL  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bcd;
  logic        loop;
  logic        stop;
  logic [3:0]  dig_sel;
  logic [3:0]  dig_code;
  logic [9:0]  dig_onehot;
  logic        scan_busy;
  logic        frame_done;
  logic        bcd_err;

  int n_checks = 0;
  int n_errors = 0;

  // Expected output vectors, one per scanned cycle.
  logic [21:0] sb[$];

  bcd_scan_controller #(.DIGITS(DIGITS), .DWELL(DWELL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bcd     (in_bcd),
    .loop       (loop),
    .stop       (stop),
    .dig_sel    (dig_sel),
    .dig_code   (dig_code),
    .dig_onehot (dig_onehot),
    .scan_busy  (scan_busy),
    .frame_done (frame_done),
    .bcd_err    (bcd_err)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] pack(input logic busy, input logic ready,
                                       input logic fd, input logic err,
                                       input logic [3:0] sel, input logic [3:0] code,
                                       input logic [9:0] oh);
    return {busy, ready, fd, err, sel, code, oh};
  endfunction

  function automatic logic [21:0] idle_vec(input logic err);
    return pack(1'b0, 1'b1, 1'b0, err, 4'h0, 4'h0, 10'h000);
  endfunction

  function automatic logic [21:0] obs_vec();
    return pack(scan_busy, in_ready, frame_done, bcd_err, dig_sel, dig_code, dig_onehot);
  endfunction

  // Expected frame: digit i held for cycles 2i+1 and 2i+2, frame_done on cycle 8.
  task automatic push_frame(input logic [15:0] w, input logic fd_on);
    for (int c = 1; c <= 8; c++) begin
      int         idx;
      logic [3:0] code;
      logic [9:0] oh;
      logic [3:0] sel;
      idx  = (c - 1) / DWELL;
      code = w[idx*4 +: 4];
      oh   = 10'h001 << code;
      sel  = 4'h1 << idx;
      sb.push_back(pack(1'b1, 1'b0, (c == 8) && fd_on, 1'b0, sel, code, oh));
    end
  endtask

  task automatic check(input string tag, input logic [21:0] obs, input logic [21:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs_vec());
    end else begin
      check(tag, obs_vec(), sb.pop_front());
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Offer a word for one edge; afterwards the bus carries junk to show it is ignored.
  task automatic handshake(input logic [15:0] w);
    in_valid = 1'b1;
    in_bcd   = w;
    advance();
    in_valid = 1'b0;
    in_bcd   = 16'hFFFF;
  endtask

  task automatic run_cycles(input string tag, input int n);
    pop_check(tag);
    for (int k = 2; k <= n; k++) begin
      advance();
      pop_check(tag);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_bcd   = 16'h0000;
    loop     = 1'b0;
    stop     = 1'b0;
    #2;
    check("reset_state", obs_vec(), idle_vec(1'b0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Plain frame, handshake on first edge after reset release.
    push_frame(16'h1234, 1'b1);
    handshake(16'h1234);
    run_cycles("frame_1234", 8);
    advance();
    check("idle_after_1234", obs_vec(), idle_vec(1'b0));

    // Rejected word, then an immediate legal word.
    handshake(16'h12A4);
    check("bcd_err_pulse", obs_vec(), idle_vec(1'b1));
    push_frame(16'h0005, 1'b1);
    handshake(16'h0005);
    run_cycles("frame_0005", 8);
    advance();
    check("idle_after_0005", obs_vec(), idle_vec(1'b0));

    // Looping: three back-to-back frames, loop dropped after cycle 20.
    loop = 1'b1;
    push_frame(16'h0909, 1'b1);
    push_frame(16'h0909, 1'b1);
    push_frame(16'h0909, 1'b1);
    handshake(16'h0909);
    pop_check("loop_0909");
    for (int k = 2; k <= 24; k++) begin
      advance();
      pop_check("loop_0909");
      if (k == 20) loop = 1'b0;
    end
    advance();
    check("idle_after_loop", obs_vec(), idle_vec(1'b0));

    // Stop in cycle 3 aborts the scan.
    push_frame(16'h1234, 1'b1);
    handshake(16'h1234);
    run_cycles("pre_stop", 3);
    stop = 1'b1;
    advance();
    check("stop_idle", obs_vec(), idle_vec(1'b0));
    sb.delete();

    // Stop held in IDLE is ignored; then stop coincides with the frame end.
    push_frame(16'h4321, 1'b0);
    handshake(16'h4321);
    stop = 1'b0;
    run_cycles("frame_4321", 7);
    advance();
    stop = 1'b1;
    pop_check("stop_at_frame_end");
    advance();
    check("idle_after_stop_end", obs_vec(), idle_vec(1'b0));
    stop = 1'b0;

    // Asynchronous reset in cycle 5, then a fresh word.
    push_frame(16'h1234, 1'b1);
    handshake(16'h1234);
    run_cycles("pre_reset", 5);
    rst_n = 1'b0;
    #1;
    check("async_reset", obs_vec(), idle_vec(1'b0));
    sb.delete();
    advance();
    check("held_reset", obs_vec(), idle_vec(1'b0));
    rst_n = 1'b1;
    push_frame(16'h9876, 1'b1);
    handshake(16'h9876);
    run_cycles("frame_9876", 8);
    advance();
    check("idle_after_9876", obs_vec(), idle_vec(1'b0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_scan_controller.md
BCD_SCAN_CONTROLLER -- requirements
Module: bcd_scan_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 The block SHALL have parameter DIGITS, default 4, giving the number of BCD digits per word (range 1..8).
REQ-003 The block SHALL have parameter DWELL, default 1000, giving the clock cycles each digit is held (at least 1).
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst_n  in  1  async active-low reset.
- in_valid  in  1  input word offered.
- in_ready  out  1  block can accept a word.
- in_bcd  in  4*DIGITS  packed BCD word; digit 0 is bits [3:0].
- loop  in  1  rescan the latched word continuously.
- stop  in  1  synchronous abort of a scan.
- dig_sel  out  DIGITS  one-hot active-digit select.
- dig_code  out  4  BCD code of the active digit.
- dig_onehot  out  10  decoded digit; bit k set when the code is k.
- scan_busy  out  1  scan in progress.
- frame_done  out  1  one-cycle end-of-frame pulse.
- bcd_err  out  1  one-cycle pulse flagging a rejected word.

Function
REQ-005 The FSM SHALL have the states IDLE and SCAN.
REQ-006 in_ready SHALL be 1 in IDLE and 0 in SCAN.
REQ-007 A handshake SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-008 If any nibble of a handshaken word exceeds 9, the block SHALL stay in IDLE, not latch the word, and assert bcd_err for exactly the next cycle.
REQ-009 If all nibbles of a handshaken word are 0..9, the block SHALL latch the word and enter SCAN with digit index 0 and dwell count 0.
REQ-010 The first digit SHALL be on the outputs in the cycle after the handshake edge (one-cycle latency).
REQ-011 In SCAN, each digit index i (0..DIGITS-1, ascending) SHALL be held for exactly DWELL cycles.
REQ-012 While digit i is held, dig_sel SHALL equal 1<<i and dig_code SHALL equal nibble i.
REQ-013 The dwell counter SHALL count from 0 to DWELL-1, then reset to 0 and advance the digit index.
REQ-014 frame_done SHALL be 1 only in the last dwell cycle of digit DIGITS-1.
REQ-015 At the end of a frame, loop is sampled: loop=1 SHALL restart at index 0 with no gap cycle; loop=0 SHALL return the FSM to IDLE.
REQ-016 stop=1 in SCAN SHALL force IDLE on the next edge without a frame_done pulse.
REQ-017 stop SHALL take priority over frame completion when both occur in the same cycle.
REQ-018 stop SHALL be ignored in IDLE.
REQ-019 In IDLE, dig_sel, dig_code, dig_onehot and scan_busy SHALL all be 0.
REQ-020 scan_busy SHALL be 1 in SCAN.
REQ-021 dig_onehot SHALL be the 1-of-10 decode of dig_code when in SCAN.
REQ-022 Latched codes are always 0..9, so dig_onehot SHALL never be all-zero while in SCAN.
REQ-023 The dwell counter SHALL be sized to clog2(DWELL) bits, minimum 1, and SHALL never wrap past DWELL-1.
REQ-024 in_bcd SHALL be ignored outside a handshake; the latched word SHALL stay stable for the whole scan.

Reset
REQ-025 While rst_n=0, the state SHALL be IDLE, the counters and latched word SHALL be 0, and all outputs except in_ready SHALL be 0.
REQ-026 in_ready SHALL be 1 during reset.
REQ-027 Reset asserted mid-scan SHALL abort the scan immediately with no frame_done pulse.
REQ-028 The first handshake SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-029 A shared package bcd_pkg SHALL hold the state encoding (IDLE, SCAN), BCD_W=4 and BCD_MAX=9.
REQ-030 The 4-to-10 decode SHALL be a combinational sub-module named bcd_digit_decoder, instantiated once on dig_code.
REQ-031 All other logic SHALL be in bcd_scan_controller.

Verification (bench uses DIGITS=4, DWELL=2)
REQ-032 Word 16'h1234, loop=0: dig_code SHALL read 4,4,3,3,2,2,1,1 over cycles 1..8 after the handshake, with dig_onehot 0x010, 0x008, 0x004, 0x002. frame_done SHALL be high in cycle 8 only, and in_ready SHALL be 1 in cycle 9.
REQ-033 Word 16'h12A4: bcd_err SHALL be high for one cycle, scan_busy SHALL stay 0, and a following word 16'h0005 SHALL be accepted on the next edge.
REQ-034 Word 16'h0909 with loop=1 for 20 cycles, then loop=0: frames SHALL repeat with no gap, with frame_done every 8 cycles. The FSM SHALL return to IDLE after the frame during which loop dropped.
REQ-035 stop pulsed in cycle 3 of a scan: the FSM SHALL be IDLE in cycle 4 with all display outputs 0, and no frame_done SHALL occur.
REQ-036 rst_n pulled low in cycle 5 of a scan: outputs SHALL go to their reset values asynchronously, and after release a word 16'h9876 SHALL scan as 6,6,7,7,8,8,9,9.
REQ-037 stop and frame_done in the same cycle: the FSM SHALL go to IDLE and frame_done SHALL stay 0.
